// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with zero/carry flags and an iterative shift-add multiply
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             c,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_INC = 3'd2,
        OP_XOR = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      step_cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     incr;
    logic [WIDTH-1:0]   shr_res;
    logic               shr_c;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [2*WIDTH-1:0] acc_step;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff    = {1'b0, a} - {1'b0, b};
    assign incr    = {1'b0, a} + (WIDTH+1)'(1);
    assign shr_res = a >> b;
    // Last bit shifted out is a[b-1]; an out-of-range mask shifts to zero for b > WIDTH.
    assign shr_c   = (b != '0) && (|(a & (WIDTH'(1) << (b - WIDTH'(1)))));

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
            end
            OP_INC: begin
                alu_res = incr[WIDTH-1:0];
                alu_c   = incr[WIDTH];
            end
            OP_XOR: alu_res = a ^ b;
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_SHR: begin
                alu_res = shr_res;
                alu_c   = shr_c;
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            step_cnt <= '0;
            result   <= '0;
            z        <= 1'b0;
            c        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand    <= {{WIDTH{1'b0}}, a};
                            mplier   <= b;
                            acc      <= '0;
                            step_cnt <= '0;
                            busy     <= 1'b1;
                            state    <= S_MUL;
                        end else begin
                            result <= alu_res;
                            z      <= (alu_res == '0);
                            c      <= alu_c;
                            done   <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // Multiplier consumed LSB-first; multiplicand walks left one place per step.
                    acc      <= acc_step;
                    mcand    <= mcand << 1;
                    mplier   <= mplier >> 1;
                    step_cnt <= step_cnt + CW'(1);
                    if (step_cnt == LAST_STEP) begin
                        result <= acc_step[WIDTH-1:0];
                        z      <= (acc_step[WIDTH-1:0] == '0);
                        c      <= |acc_step[2*WIDTH-1:WIDTH];
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, INC = 3'd2, XOR = 3'd3;
    localparam logic [2:0] AND = 3'd4, OR = 3'd5, SHR = 3'd6, MUL = 3'd7;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_v [2];
    logic [2:0]  op_v    [2];
    logic [31:0] a_v     [2];
    logic [31:0] b_v     [2];
    logic [7:0]  res8;
    logic [15:0] res16;
    logic [31:0] d_res   [2];
    logic        z_v     [2];
    logic        c_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start_v[0]), .op(op_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .result(res8),
        .z(z_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start_v[1]), .op(op_v[1]),
        .a(a_v[1][15:0]), .b(b_v[1][15:0]), .result(res16),
        .z(z_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    assign d_res[0] = {24'd0, res8};
    assign d_res[1] = {16'd0, res16};

    int n_chk = 0;
    int n_err = 0;

    function automatic int wof(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    // Returns {carry, result} straight from the arithmetic definitions.
    function automatic logic [32:0] mdl(input int w, input logic [2:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
        longint unsigned m, ua, ub, r;
        logic cf;
        m  = (64'd1 << w) - 64'd1;
        ua = x & m;
        ub = y & m;
        r  = 0;
        cf = 1'b0;
        case (o)
            ADD: begin r = ua + ub; cf = (r > m); end
            SUB: begin r = ua - ub; cf = (ua < ub); end
            INC: begin r = ua + 1; cf = (ua == m); end
            XOR: r = ua ^ ub;
            AND: r = ua & ub;
            OR:  r = ua | ub;
            SHR: begin
                r  = (ub >= 64'(w)) ? 0 : (ua >> ub);
                cf = (ub == 0 || ub > 64'(w)) ? 1'b0 : (((ua >> (ub - 1)) & 1) != 0);
            end
            default: begin r = ua * ub; cf = ((r >> w) != 0); end
        endcase
        r = r & m;
        return {cf, r[31:0]};
    endfunction

    logic [32:0] m_next [2];
    int          m_cnt  [2];
    logic [32:0] m_pend [2];
    logic [31:0] m_res  [2];
    logic        m_z    [2];
    logic        m_c    [2];
    logic        m_done [2];

    always_comb begin
        for (int i = 0; i < 2; i++) m_next[i] = mdl(wof(i), op_v[i], a_v[i], b_v[i]);
    end

    // Transaction-level model: single ops finish next edge, MUL after WIDTH more edges.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_done[i] <= 1'b0;
            if (reset) begin
                m_cnt[i] <= 0;
                m_res[i] <= '0;
                m_z[i]   <= 1'b0;
                m_c[i]   <= 1'b0;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] <= m_cnt[i] - 1;
                if (m_cnt[i] == 1) begin
                    m_res[i]  <= m_pend[i][31:0];
                    m_z[i]    <= (m_pend[i][31:0] == 0);
                    m_c[i]    <= m_pend[i][32];
                    m_done[i] <= 1'b1;
                end
            end else if (start_v[i]) begin
                if (op_v[i] == MUL) begin
                    m_cnt[i]  <= wof(i);
                    m_pend[i] <= m_next[i];
                end else begin
                    m_res[i]  <= m_next[i][31:0];
                    m_z[i]    <= (m_next[i][31:0] == 0);
                    m_c[i]    <= m_next[i][32];
                    m_done[i] <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("w%0d cycle {busy,done,z,c,result}", wof(i)),
                      {busy_v[i], done_v[i], z_v[i], c_v[i], d_res[i]},
                      {(m_cnt[i] > 0), m_done[i], m_z[i], m_c[i], m_res[i]});
            end
        end
    end

    task automatic do_op(input int i, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start_v[i] = 1'b1;
        op_v[i]    = o;
        a_v[i]     = x;
        b_v[i]     = y;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic lit(input int i, input string nm, input logic [31:0] r,
                       input logic zz, input logic cc, input logic dd);
        check($sformatf("w%0d %s {done,z,c,result}", wof(i), nm),
              {1'b0, done_v[i], z_v[i], c_v[i], d_res[i]}, {1'b0, dd, zz, cc, r});
    endtask

    task automatic wait_done(input int i, input bit inj, output int cyc);
        int g;
        cyc = 0;
        g   = 0;
        while (done_v[i] !== 1'b1 && g < 64) begin
            if (busy_v[i] === 1'b1) cyc++;
            if (inj) begin
                start_v[i] = (cyc == 3);
                op_v[i]    = ADD;
                a_v[i]     = 32'h7;
                b_v[i]     = 32'h9;
            end
            @(negedge clk);
            g++;
        end
        start_v[i] = 1'b0;
        check($sformatf("w%0d mul done within bound", wof(i)), {35'd0, done_v[i]}, 36'd1);
    endtask

    int cyc;

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; op_v[i] = ADD; a_v[i] = '0; b_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        lit(0, "reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check("w8 reset busy", {35'd0, busy_v[0]}, 36'd0);
        reset = 1'b0;

        do_op(0, ADD, 32'hF0, 32'h10);  lit(0, "add f0+10", 32'h00, 1, 1, 1);
        @(negedge clk);                 lit(0, "add done drops", 32'h00, 1, 1, 0);
        do_op(0, SUB, 32'h05, 32'h07);  lit(0, "sub 05-07", 32'hFE, 0, 1, 1);
        do_op(0, SUB, 32'h07, 32'h07);  lit(0, "sub 07-07 b2b", 32'h00, 1, 0, 1);
        do_op(0, INC, 32'hFF, 32'h00);  lit(0, "inc ff", 32'h00, 1, 1, 1);
        do_op(0, SHR, 32'h81, 32'h01);  lit(0, "shr 81>>1", 32'h40, 0, 1, 1);
        do_op(0, SHR, 32'h81, 32'h09);  lit(0, "shr 81>>9", 32'h00, 1, 0, 1);
        do_op(0, SHR, 32'h81, 32'h08);  lit(0, "shr 81>>8", 32'h00, 1, 1, 1);
        do_op(0, SHR, 32'h81, 32'h00);  lit(0, "shr 81>>0", 32'h81, 0, 0, 1);
        do_op(0, XOR, 32'hA5, 32'h5A);  lit(0, "xor", 32'hFF, 0, 0, 1);
        do_op(0, OR,  32'h30, 32'h03);  lit(0, "or", 32'h33, 0, 0, 1);
        @(negedge clk);

        do_op(0, MUL, 32'h10, 32'h12);
        wait_done(0, 1'b1, cyc);
        check("w8 mul busy cycles", 36'(cyc), 36'd8);
        lit(0, "mul 10*12", 32'h20, 0, 1, 1);
        repeat (2) @(negedge clk);
        lit(0, "mul result held", 32'h20, 0, 1, 0);

        reset = 1'b1;
        start_v[0] = 1'b1; op_v[0] = ADD; a_v[0] = 32'h1; b_v[0] = 32'h1;
        @(negedge clk);
        reset = 1'b0; start_v[0] = 1'b0;
        lit(0, "reset beats start", 32'h00, 0, 0, 0);

        do_op(0, MUL, 32'h03, 32'h05);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lit(0, "reset mid mul", 32'h00, 0, 0, 0);
        check("w8 busy after abort", {35'd0, busy_v[0]}, 36'd0);
        do_op(0, MUL, 32'h03, 32'h05);
        wait_done(0, 1'b0, cyc);
        check("w8 mul 3*5 busy cycles", 36'(cyc), 36'd8);
        lit(0, "mul 3*5", 32'h0F, 0, 0, 1);

        do_op(1, MUL, 32'h0100, 32'h0100);
        wait_done(1, 1'b1, cyc);
        check("w16 mul busy cycles", 36'(cyc), 36'd16);
        lit(1, "mul 0100*0100", 32'h0000, 1, 1, 1);
        do_op(1, AND, 32'hF0F0, 32'h0FF0);
        lit(1, "and", 32'h00F0, 0, 0, 1);
        do_op(1, ADD, 32'hFFFF, 32'h0001);
        lit(1, "add ffff+1", 32'h0000, 1, 1, 1);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU.
- Adds WIDTH generalisation, AND/OR/SHR ops and an iterative multi-cycle multiply.
- Produces zero (z) and carry/borrow/overflow (c) flags for every op.
- Sits between the register file read ports and the writeback mux; the control FSM drives start/op and waits on done.

Parameters:
WIDTH  8  operand/result width in bits (legal: 4..32)

Ports:
clk     input   1      system clock, all state updates on rising edge
reset   input   1      synchronous, active-high reset
start   input   1      request: sample op/a/b this edge (ignored while busy)
op      input   3      0 ADD, 1 SUB, 2 INC, 3 XOR, 4 AND, 5 OR, 6 SHR, 7 MUL
a       input   WIDTH  first operand (r0/rd source)
b       input   WIDTH  second operand (rs source)
result  output  WIDTH  registered result, held until next completion
z       output  1      registered: result == 0
c       output  1      registered: carry/borrow/overflow, op-dependent
busy    output  1      high while MUL is iterating
done    output  1      one-cycle pulse when result/z/c update

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: result=0, z=0, c=0, busy=0, done=0, state=IDLE, internal accumulators=0.
- States:
  - IDLE: start=1 with op 0-6 computes the op, registers result/z/c and pulses done at the same edge; stays in IDLE.
  - IDLE: start=1 with op=7 latches a (multiplicand), b (multiplier), clears the 2*WIDTH accumulator and the iteration counter, sets busy=1, and moves to MUL.
  - MUL: one shift-add step per cycle, LSB-first over b; exactly WIDTH steps.
  - MUL, final step edge: result = acc[WIDTH-1:0], c = |acc[2*WIDTH-1:WIDTH], z = (result==0), done=1, busy=0, back to IDLE.
- Latency:
  - ops 0-6: start sampled at edge N; outputs valid and done=1 in the cycle after edge N.
  - MUL: start at edge N; busy=1 for cycles after edges N..N+WIDTH-1; done=1 and outputs valid in the cycle after edge N+WIDTH.
- Back-to-back: start may be asserted in the cycle done is high (IDLE); a new single-cycle op produces done on consecutive cycles.
- start while busy: ignored entirely; operands are not re-sampled and the MUL is unaffected.
- done: exactly one cycle per accepted start; never high while busy.
- result/z/c change only on done edges or reset.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: c = carry out of bit WIDTH-1.
  - SUB: a-b; c = borrow (a<b unsigned).
  - INC: a+1; c = (a == all ones).
  - XOR/AND/OR: c=0.
  - SHR: logical a >> b, b unsigned; any b >= WIDTH gives 0; c = last bit shifted out (0 if b=0; 0 if b > WIDTH; a[WIDTH-1] if b==WIDTH).
  - MUL: unsigned; c = upper half nonzero.
- z = (result == 0) for every op, including ADD/INC/MUL.
- Reset mid-MUL: aborts immediately; all outputs to reset values; no done pulse; the next start is accepted the cycle after reset deasserts.
- Reset and start in the same cycle: reset wins; start is dropped.

Test Plan:
- WIDTH=8, ADD a=0xF0 b=0x10 start pulse -> next cycle result=0x00 z=1 c=1 done=1 for one cycle only.
- SUB a=0x05 b=0x07 -> result=0xFE z=0 c=1; then SUB a=0x07 b=0x07 back-to-back -> result=0x00 z=1 c=0, done high two consecutive cycles.
- INC a=0xFF -> result=0x00 z=1 c=1; SHR a=0x81 b=1 -> result=0x40 c=1; SHR b=9 -> result=0x00 z=1 c=0.
- MUL a=0x10 b=0x12 at edge N -> busy for 8 cycles, done in the cycle after edge N+8, result=0x20 c=1 z=0; start pulses with other operands while busy are ignored and the result is unchanged.
- Assert reset at cycle 3 of MUL a=3 b=5 -> no done, all outputs 0; then MUL a=3 b=5 -> result=0x0F c=0 after 8 cycles.
- Param WIDTH=16 rerun: MUL 0x0100*0x0100 -> result=0x0000 z=1 c=1 after 16 cycles; AND 0xF0F0&0x0FF0 -> 0x00F0.
